// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes SPI command bytes and drives a single-cycle register bus.
// Write mode stores bytes at an auto-incrementing address. Read mode prefetches
// register bytes into the slave transmit path. Each transaction end preloads a
// status byte (completed-transaction count) for the next transaction's first MISO byte.
module spi_reg_bridge #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_strobe,
  input  logic              rx_start,
  input  logic              rx_end_strobe,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_strobe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [7:0]        txn_count
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic              re_q;
  logic              rd_phase;
  logic              stat_load;
  logic              rst_d;
  logic [DATA_W-1:0] tx_q;

  logic              byte_ok;
  logic              is_cmd;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        count_next;

  // Byte qualification and command decode; an end strobe discards a coincident byte.
  always_comb begin
    byte_ok    = rx_data_strobe & ~rx_end_strobe;
    is_cmd     = byte_ok & rx_start;
    cmd_write  = rx_data[DATA_W-1];
    cmd_addr   = rx_data[ADDR_W-1:0];
    count_next = (state != IDLE) ? txn_count + 8'd1 : txn_count;
  end

  // A request queued by the previous byte is suppressed if the transaction ends
  // in its issue cycle, so it never reaches the bus.
  assign reg_we = we_q & ~rx_end_strobe;
  assign reg_re = re_q & ~rx_end_strobe;

  // Read data is forwarded from reg_rdata in its landing cycle (it arrives one
  // cycle after reg_re), then held in tx_q until the next load.
  assign tx_data_strobe = stat_load | rd_phase;
  assign tx_data        = rd_phase ? reg_rdata : tx_q;
  assign busy           = (state != IDLE);

  // Transaction FSM, address counter, bus request and transmit-load registers.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      txn_count <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_q      <= '0;
      stat_load <= 1'b0;
      rd_phase  <= 1'b0;
      rst_d     <= 1'b1;
    end else begin
      rst_d     <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      stat_load <= 1'b0;
      rd_phase  <= reg_re;
      if (rd_phase) begin
        tx_q <= reg_rdata;
      end
      if (rst_d) begin
        stat_load <= 1'b1;
        tx_q      <= '0;
      end
      if (rx_end_strobe) begin
        state     <= IDLE;
        txn_count <= count_next;
        tx_q      <= count_next;
        stat_load <= 1'b1;
      end else if (is_cmd) begin
        if (cmd_write) begin
          state <= WRITE;
          addr  <= cmd_addr;
        end else begin
          state    <= READ;
          re_q     <= 1'b1;
          reg_addr <= cmd_addr;
          addr     <= cmd_addr + ADDR_STEP;
        end
      end else if (byte_ok) begin
        case (state)
          WRITE: begin
            we_q      <= 1'b1;
            reg_addr  <= addr;
            reg_wdata <= rx_data;
            addr      <= addr + ADDR_STEP;
          end
          READ: begin
            re_q     <= 1'b1;
            reg_addr <= addr;
            addr     <= addr + ADDR_STEP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed and randomized stimulus for spi_reg_bridge, checked
// every cycle against a transaction-level model that schedules expected bus and
// transmit events by cycle number.
module tb_spi_reg_bridge;

  logic       CLK_40 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_data_strobe = 1'b0;
  logic       rx_start = 1'b0;
  logic       rx_end_strobe = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_strobe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] txn_count;

  spi_reg_bridge #(.ADDR_W(7), .DATA_W(8)) dut (
    .CLK_40(CLK_40), .reset(reset), .rx_data(rx_data), .rx_data_strobe(rx_data_strobe),
    .rx_start(rx_start), .rx_end_strobe(rx_end_strobe), .tx_data(tx_data),
    .tx_data_strobe(tx_data_strobe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
    .txn_count(txn_count)
  );

  always #5 CLK_40 = ~CLK_40;

  // Register slave: reg[i] = i ^ 0xA0 with one-cycle read latency; noise otherwise.
  always @(posedge CLK_40) begin
    if (reg_re === 1'b1) reg_rdata <= {1'b0, reg_addr} ^ 8'hA0;
    else reg_rdata <= 8'($urandom);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0=idle 1=write 2=read; expected events keyed by cycle.
  int         cyc = 0;
  bit         started = 0;
  bit         rst_last = 0;
  bit         pend_rst = 0;
  int         mode = 0;
  logic [6:0] maddr = '0;
  logic [7:0] mcount = '0;
  logic [7:0] last_tx = '0;
  bit   [1:0] bus_kind[int];
  logic [6:0] bus_addr[int];
  logic [7:0] bus_data[int];
  logic [7:0] tx_exp[int];
  logic [15:0] we_log[$];
  logic [15:0] re_log[$];
  logic [15:0] tx_log[$];
  bit         we_e, re_e;

  task automatic sched_read();
    bus_kind[cyc+1] = 2'd2;
    bus_addr[cyc+1] = maddr;
    tx_exp[cyc+2]   = {1'b0, maddr} ^ 8'hA0;
    maddr++;
  endtask

  task automatic sched_write();
    bus_kind[cyc+1] = 2'd1;
    bus_addr[cyc+1] = maddr;
    bus_data[cyc+1] = rx_data;
    maddr++;
  endtask

  // Compare just before each rising edge, then advance the model with that cycle's inputs.
  always begin : compare
    @(negedge CLK_40);
    #4;
    if (started) begin
      we_e = 1'b0;
      re_e = 1'b0;
      if (bus_kind.exists(cyc) && !rx_end_strobe) begin
        we_e = (bus_kind[cyc] == 2'd1);
        re_e = (bus_kind[cyc] == 2'd2);
      end
      chk("reg_we", reg_we, we_e);
      chk("reg_re", reg_re, re_e);
      if (we_e || re_e) chk("reg_addr", reg_addr, bus_addr[cyc]);
      if (we_e) chk("reg_wdata", reg_wdata, bus_data[cyc]);
      if (rst_last) begin
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
      end
      if (tx_exp.exists(cyc)) begin
        chk("tx_strobe", tx_data_strobe, 1);
        chk("tx_data", tx_data, tx_exp[cyc]);
        last_tx = tx_exp[cyc];
      end else begin
        chk("tx_strobe", tx_data_strobe, 0);
        chk("tx_hold", tx_data, last_tx);
      end
      chk("busy", busy, (mode != 0));
      chk("txn_count", txn_count, mcount);
      if (reg_we === 1'b1) we_log.push_back({1'b0, reg_addr, reg_wdata});
      if (reg_re === 1'b1) re_log.push_back({9'd0, reg_addr});
      if (tx_data_strobe === 1'b1) tx_log.push_back({8'd0, tx_data});
    end
    if (reset) begin
      bus_kind.delete();
      bus_addr.delete();
      bus_data.delete();
      tx_exp.delete();
      mode = 0;
      maddr = '0;
      mcount = '0;
      last_tx = '0;
      started = 1;
      rst_last = 1;
      pend_rst = 1;
    end else if (started) begin
      rst_last = 0;
      if (pend_rst) tx_exp[cyc+1] = 8'h00;
      pend_rst = 0;
      if (rx_end_strobe) begin
        if (mode != 0) mcount++;
        mode = 0;
        tx_exp[cyc+1] = mcount;
      end else if (rx_data_strobe && rx_start) begin
        maddr = rx_data[6:0];
        if (rx_data[7]) mode = 1;
        else begin
          mode = 2;
          sched_read();
        end
      end else if (rx_data_strobe) begin
        if (mode == 1) sched_write();
        else if (mode == 2) sched_read();
      end
    end
    if (bus_kind.exists(cyc)) bus_kind.delete(cyc);
    if (tx_exp.exists(cyc)) tx_exp.delete(cyc);
    cyc++;
  end

  task automatic drive(input logic s, input logic st, input logic [7:0] d, input logic e);
    @(negedge CLK_40);
    reset = 1'b0;
    rx_data_strobe = s;
    rx_start = st;
    rx_data = d;
    rx_end_strobe = e;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) begin
      @(negedge CLK_40);
      reset = 1'b1;
      rx_data_strobe = 1'b0;
      rx_start = 1'b0;
      rx_end_strobe = 1'b0;
    end
  endtask

  task automatic clear_logs();
    we_log.delete();
    re_log.delete();
    tx_log.delete();
  endtask

  task automatic do_reset();
    rst_cycles(3);
    gap(4);
    clear_logs();
  endtask

  task automatic cmp_q(input string nm, input logic [15:0] act[$], input logic [15:0] exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < act.size()) chk(nm, act[i], exp[i]);
  endtask

  logic [15:0] e[$];

  initial begin : stimulus
    rst_cycles(2);
    gap(3);

    // Reset asserted for 3 cycles in the middle of a write burst.
    drive(1'b1, 1'b1, 8'h81, 1'b0);
    gap(1);
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    rst_cycles(3);
    #4;
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_txs", tx_data_strobe, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", txn_count, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge CLK_40);
    #4;
    chk("rel_txs", tx_data_strobe, 1);
    chk("rel_tx", tx_data, 0);
    chk("rel_we", reg_we, 0);

    // Write burst.
    do_reset();
    drive(1'b1, 1'b1, 8'h85, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'h11, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'h22, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'h33, 1'b0); gap(2);
    drive(1'b0, 1'b0, 8'h00, 1'b1); gap(3);
    e = {16'h0511, 16'h0622, 16'h0733};
    cmp_q("wr_burst", we_log, e);
    chk("wr_no_re", re_log.size(), 0);
    chk("wr_count", txn_count, 1);
    e = {16'h0001};
    cmp_q("wr_status", tx_log, e);

    // Read burst.
    do_reset();
    drive(1'b1, 1'b1, 8'h10, 1'b0); gap(2);
    drive(1'b1, 1'b0, 8'($urandom), 1'b0); gap(2);
    drive(1'b1, 1'b0, 8'($urandom), 1'b0); gap(3);
    drive(1'b0, 1'b0, 8'h00, 1'b1); gap(3);
    e = {16'h0010, 16'h0011, 16'h0012};
    cmp_q("rd_addr", re_log, e);
    e = {16'h00B0, 16'h00B1, 16'h00B2, 16'h0001};
    cmp_q("rd_tx", tx_log, e);
    chk("rd_no_we", we_log.size(), 0);

    // Address wrap.
    clear_logs();
    drive(1'b1, 1'b1, 8'hFF, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'hAA, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'hBB, 1'b0); gap(2);
    drive(1'b0, 1'b0, 8'h00, 1'b1); gap(3);
    e = {16'h7FAA, 16'h00BB};
    cmp_q("wrap", we_log, e);

    // End one cycle after a read data strobe, then end coincident with a write byte.
    do_reset();
    drive(1'b1, 1'b1, 8'h20, 1'b0); gap(3);
    drive(1'b1, 1'b0, 8'($urandom), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1); gap(3);
    e = {16'h0020};
    cmp_q("abort_re", re_log, e);
    e = {16'h0080, 16'h0001};
    cmp_q("abort_tx", tx_log, e);
    clear_logs();
    drive(1'b1, 1'b1, 8'h83, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'h44, 1'b1); gap(3);
    chk("coll_no_we", we_log.size(), 0);
    chk("coll_count", txn_count, 2);
    e = {16'h0002};
    cmp_q("coll_tx", tx_log, e);

    // Idle noise: data strobes without a command.
    clear_logs();
    repeat (3) begin
      drive(1'b1, 1'b0, 8'h55, 1'b0);
      gap(1);
    end
    gap(2);
    chk("idle_we", we_log.size(), 0);
    chk("idle_re", re_log.size(), 0);
    chk("idle_busy", busy, 0);

    // Restart mid-read with a write command.
    clear_logs();
    drive(1'b1, 1'b1, 8'h30, 1'b0); gap(2);
    drive(1'b1, 1'b1, 8'h8A, 1'b0); gap(1);
    drive(1'b1, 1'b0, 8'h77, 1'b0); gap(2);
    drive(1'b0, 1'b0, 8'h00, 1'b1); gap(3);
    e = {16'h0030};
    cmp_q("restart_re", re_log, e);
    e = {16'h0A77};
    cmp_q("restart_we", we_log, e);

    // 256 transactions wrap the counter.
    do_reset();
    repeat (256) begin
      drive(1'b1, 1'b1, 8'($urandom), 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    gap(2);
    chk("cnt_wrap", txn_count, 0);
    chk("cnt_wrap_tx", tx_data, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_cycles($urandom_range(1, 3));
      end else begin
        automatic logic s  = ($urandom_range(0, 2) == 0);
        automatic logic st = s && ($urandom_range(0, 3) == 0);
        automatic logic en = ($urandom_range(0, 9) == 0);
        drive(s, st, 8'($urandom), en);
      end
    end
    gap(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
